// File: rtl/axis_uart_rx_fifo.sv
// Byte FIFO between a UART receiver and an AXI-Stream consumer.
// Show-ahead registered output, sticky overflow with drop counter, fill-level interrupt.
module axis_uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    s_axis_tdata_i,
    input  logic          s_axis_tvalid_i,
    output logic          s_axis_tready_o,
    output logic [7:0]    m_axis_tdata_o,
    output logic          m_axis_tvalid_o,
    input  logic          m_axis_tready_i,
    input  logic          flush_i,
    input  logic          ovf_clr_i,
    input  logic [AW:0]   level_thresh_i,
    output logic [AW:0]   level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          thresh_irq_o,
    output logic          overflow_o,
    output logic [7:0]    drop_cnt_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [AW:0]   r_level, w_level_after_rd, w_level_nxt;
    logic [7:0]    r_tdata, w_head_nxt, r_drop_cnt;
    logic          r_tvalid, r_empty, r_full, r_irq, r_ovf;
    logic          w_rd, w_wr, w_drop, w_irq_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rd             = r_tvalid & m_axis_tready_i;
        w_wr             = s_axis_tvalid_i & ~flush_i & (~r_full | w_rd);
        w_drop           = s_axis_tvalid_i & ~flush_i & r_full & ~w_rd;
        w_level_after_rd = r_level - {{AW{1'b0}}, w_rd};
        w_level_nxt      = w_level_after_rd + {{AW{1'b0}}, w_wr};
        w_rd_ptr_nxt     = r_rd_ptr + {{(AW-1){1'b0}}, w_rd};
        w_wr_ptr_nxt     = r_wr_ptr + {{(AW-1){1'b0}}, w_wr};
        // With nothing left behind the read, the incoming byte bypasses memory to the head.
        w_head_nxt       = (w_level_after_rd == '0) ? s_axis_tdata_i : r_mem[w_rd_ptr_nxt];
        w_irq_nxt        = (level_thresh_i != '0) && (w_level_nxt >= level_thresh_i);
    end

    // NOTE: storage has no reset; pointers and level alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= s_axis_tdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_irq      <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_irq      <= 1'b0;
            r_tvalid   <= 1'b0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_empty  <= (w_level_nxt == '0);
            r_full   <= (w_level_nxt == FULL_LVL);
            r_irq    <= w_irq_nxt;
            r_tvalid <= (w_level_nxt != '0);
            if (w_level_nxt != '0) r_tdata <= w_head_nxt;
            // A drop in the same cycle as a clear wins and restarts the count at one.
            if (w_drop) begin
                r_ovf      <= 1'b1;
                r_drop_cnt <= ovf_clr_i ? 8'd1
                            : (r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1;
            end else if (ovf_clr_i) begin
                r_ovf      <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign s_axis_tready_o = 1'b1;
    assign m_axis_tdata_o  = r_tdata;
    assign m_axis_tvalid_o = r_tvalid;
    assign level_o         = r_level;
    assign empty_o         = r_empty;
    assign full_o          = r_full;
    assign thresh_irq_o    = r_irq;
    assign overflow_o      = r_ovf;
    assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// Directed self-checking bench for axis_uart_rx_fifo at DEPTH=16.
module tb_axis_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          flush;
    logic          ovf_clr;
    logic [AW:0]   thresh;
    logic [AW:0]   level;
    logic          empty, full, irq, ovf;
    logic [7:0]    drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q[$];

    axis_uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .flush_i         (flush),
        .ovf_clr_i       (ovf_clr),
        .level_thresh_i  (thresh),
        .level_o         (level),
        .empty_o         (empty),
        .full_o          (full),
        .thresh_irq_o    (irq),
        .overflow_o      (ovf),
        .drop_cnt_o      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        s_tdata  = b;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        flush = 1'b0; ovf_clr = 1'b0; thresh = '0;
        #12;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_irq", irq, 0);
        check("s_tready", s_tready, 1);
        step();
        rst_n = 1'b1;
        step();

        // Single byte through an empty FIFO.
        m_tready = 1'b1;
        put(8'hA5);
        check("one_tvalid", m_tvalid, 1);
        check("one_tdata", m_tdata, 8'hA5);
        check("one_level1", level, 1);
        step();
        check("one_level0", level, 0);
        check("one_empty", empty, 1);
        check("one_tvalid0", m_tvalid, 0);

        // Fill past capacity with the consumer stalled.
        m_tready = 1'b0;
        for (int i = 0; i < 18; i++) put(8'(i));
        check("fill_full", full, 1);
        check("fill_level", level, 16);
        check("fill_ovf", ovf, 1);
        check("fill_drop", drop_cnt, 2);
        check("fill_head", m_tdata, 8'h00);

        // Drop coinciding with a clear leaves the flag set and the count at one.
        ovf_clr = 1'b1;
        put(8'hEE);
        ovf_clr = 1'b0;
        check("clrdrop_ovf", ovf, 1);
        check("clrdrop_cnt", drop_cnt, 1);

        s_tdata = 8'hEE;
        s_tvalid = 1'b1;
        repeat (260) step();
        s_tvalid = 1'b0;
        check("drop_sat", drop_cnt, 255);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_cnt", drop_cnt, 0);
        check("clr_level", level, 16);

        // Write while full with a concurrent read.
        m_tready = 1'b1;
        check("conc_head", m_tdata, 8'h00);
        put(8'h55);
        check("conc_level", level, 16);
        check("conc_full", full, 1);
        check("conc_ovf", ovf, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d_valid", i), m_tvalid, 1);
            check($sformatf("drain%0d_data", i), m_tdata, (i < 15) ? 8'(i + 1) : 8'h55);
            step();
        end
        check("drain_empty", empty, 1);
        check("drain_level", level, 0);

        // Threshold interrupt.
        m_tready = 1'b0;
        thresh = 5'd4;
        for (int i = 0; i < 4; i++) begin
            put(8'hA0 + 8'(i));
            check($sformatf("irq_w%0d", i), irq, (i == 3) ? 1 : 0);
        end
        check("irq_level", level, 4);
        m_tready = 1'b1;
        step();
        check("irq_fall", irq, 0);
        check("irq_level3", level, 3);
        check("irq_head", m_tdata, 8'hA1);
        put(8'hB0);
        check("mid_conc_level", level, 3);
        check("mid_conc_head", m_tdata, 8'hA2);
        m_tready = 1'b0;
        thresh = 5'd3;
        step();
        check("irq_eq", irq, 1);
        thresh = 5'd0;
        step();
        check("irq_disabled", irq, 0);
        thresh = 5'd20;
        step();
        check("irq_over_depth", irq, 0);
        m_tready = 1'b1;
        check("tail0", m_tdata, 8'hA2); step();
        check("tail1", m_tdata, 8'hA3); step();
        check("tail2", m_tdata, 8'hB0); step();
        check("tail_empty", empty, 1);

        // Traffic with random consumer stalls to wrap the pointers.
        begin
            int written = 0;
            int cyc = 0;
            while (written < 40 && cyc < 400) begin
                logic do_wr;
                do_wr    = cyc[0] && !full;
                m_tready = ($urandom_range(0, 3) != 0);
                s_tdata  = 8'h40 + 8'(written);
                s_tvalid = do_wr;
                check("rnd_valid", m_tvalid, (q.size() != 0) ? 1 : 0);
                if (m_tvalid && m_tready && q.size() != 0) check("rnd_data", m_tdata, q.pop_front());
                if (do_wr) begin
                    q.push_back(s_tdata);
                    written++;
                end
                step();
                cyc++;
            end
            s_tvalid = 1'b0;
            m_tready = 1'b1;
            cyc = 0;
            while (q.size() != 0 && cyc < 100) begin
                check("rnd_tail", m_tdata, q.pop_front());
                step();
                cyc++;
            end
            check("rnd_drained", q.size(), 0);
            check("rnd_empty", empty, 1);
        end

        // Flush at level 5 with a write pending.
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) put(8'hC0 + 8'(i));
        check("pre_flush_level", level, 5);
        flush = 1'b1;
        put(8'hEE);
        flush = 1'b0;
        check("flush_level", level, 0);
        check("flush_tvalid", m_tvalid, 0);
        check("flush_ovf", ovf, 0);
        check("flush_empty", empty, 1);
        step();
        check("flush_lost", level, 0);
        m_tready = 1'b1;
        put(8'h11);
        check("post_flush_data", m_tdata, 8'h11);
        step();

        // Asynchronous reset mid-operation.
        m_tready = 1'b0;
        thresh = 5'd4;
        for (int i = 0; i < 7; i++) put(8'h10 + 8'(i));
        check("pre_rst_level", level, 7);
        check("pre_rst_irq", irq, 1);
        s_tdata  = 8'h99;
        s_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_level", level, 0);
        check("arst_tvalid", m_tvalid, 0);
        check("arst_tdata", m_tdata, 0);
        check("arst_empty", empty, 1);
        check("arst_irq", irq, 0);
        s_tvalid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rel_level", level, 0);
        put(8'h3C);
        check("rel_tvalid", m_tvalid, 1);
        check("rel_tdata", m_tdata, 8'h3C);
        check("rel_level1", level, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_uart_rx_fifo.md
AXIS_UART_RX_FIFO -- requirements
Module: axis_uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, total byte capacity; power of two, at least 4.
REQ-002 SHALL derive AW = log2(DEPTH); status counters are AW+1 bits wide.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata_i  in  8  received byte from the UART receiver.
REQ-006 SHALL have port s_axis_tvalid_i  in  1  byte valid from the UART receiver.
REQ-007 SHALL have port s_axis_tready_o  out  1  constant 1; accept-and-drop policy.
REQ-008 SHALL have port m_axis_tdata_o  out  8  head byte to the consumer.
REQ-009 SHALL have port m_axis_tvalid_o  out  1  head byte valid.
REQ-010 SHALL have port m_axis_tready_i  in  1  consumer ready.
REQ-011 SHALL have port flush_i  in  1  synchronous flush, one-cycle pulse or level.
REQ-012 SHALL have port ovf_clr_i  in  1  clears the sticky overflow flag.
REQ-013 SHALL have port level_thresh_i  in  AW+1  fill threshold for the interrupt; 0 disables it.
REQ-014 SHALL have port level_o  out  AW+1  bytes held, 0..DEPTH.
REQ-015 SHALL have ports empty_o, full_o  out  1 each  level_o==0 and level_o==DEPTH.
REQ-016 SHALL have port thresh_irq_o  out  1  high while level_o>=level_thresh_i and level_thresh_i!=0.
REQ-017 SHALL have port overflow_o  out  1  sticky, set when a byte is dropped.
REQ-018 SHALL have port drop_cnt_o  out  8  saturating count of dropped bytes.

Function
REQ-019 Write event SHALL be s_axis_tvalid_i==1 in a cycle; every such cycle is exactly one byte.
REQ-020 Read event SHALL be m_axis_tvalid_o && m_axis_tready_i.
REQ-021 Ordering SHALL be strict FIFO order; no byte duplicated or reordered.
REQ-022 Storage SHALL be a DEPTH-entry circular buffer, read/write pointers AW bits wide, wrapping from DEPTH-1 to 0.
REQ-023 m_axis_tdata_o SHALL be registered (show-ahead): a write into an empty FIFO makes m_axis_tvalid_o=1 with that byte on the next edge.
REQ-024 While m_axis_tvalid_o=1 and m_axis_tready_i=0, m_axis_tdata_o and m_axis_tvalid_o SHALL hold stable.
REQ-025 Simultaneous write and read on an empty FIFO SHALL be impossible; m_axis_tvalid_o is 0 in that case.
REQ-026 Simultaneous write and read when 0<level<DEPTH SHALL leave level_o unchanged and advance both pointers.
REQ-027 Write when full with no read in the same cycle SHALL drop the byte, set overflow_o, increment drop_cnt_o (saturating at 255) and leave contents untouched.
REQ-028 Write when full with a read in the same cycle SHALL accept the byte with no overflow; level_o stays at DEPTH.
REQ-029 level_o, empty_o, full_o and thresh_irq_o SHALL be registered and update on the same edge as the pointers they describe.
REQ-030 flush_i=1 SHALL, on that edge, zero the pointers, level_o and drop_cnt_o, set m_axis_tvalid_o=0 and clear overflow_o; a write in the flush cycle is discarded and does not count as overflow.
REQ-031 ovf_clr_i=1 SHALL clear overflow_o and drop_cnt_o; a drop in the same cycle wins, leaving overflow_o=1 and drop_cnt_o=1.
REQ-032 A level_thresh_i value greater than DEPTH SHALL keep thresh_irq_o at 0.

Reset
REQ-033 rst_n low SHALL immediately force pointers=0, level_o=0, empty_o=1, full_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, thresh_irq_o=0, overflow_o=0 and drop_cnt_o=0.
REQ-034 Reset mid-transfer SHALL discard all stored bytes; the first valid byte after release is the first output.
REQ-035 Buffer memory contents SHALL NOT need a reset.

Verification
REQ-036 Single byte: write 0xA5 into an empty FIFO, tready=1 -> tvalid=1, tdata=0xA5 one cycle later; level_o goes 1 then 0; empty_o returns to 1.
REQ-037 Fill and overflow, DEPTH=16: write 0x00..0x11 (18 bytes) with tready=0 -> full_o=1, level_o=16, overflow_o=1, drop_cnt_o=2; drain yields 0x00..0x0F in order.
REQ-038 Full with concurrent read: at level 16, write 0x55 while tready=1 -> no overflow, level_o stays 16, 0x55 emerges 16th after the current head.
REQ-039 Threshold: level_thresh_i=4; write 4 bytes -> thresh_irq_o rises on the edge level_o becomes 4 and falls after the first read.
REQ-040 Flush and wrap: run 40 bytes through with random tready to exercise pointer wrap, then pulse flush_i with level 5 and a write pending -> level_o=0, tvalid=0, overflow_o=0, pending byte lost.
REQ-041 Reset mid-operation: assert rst_n low at level 7 with tvalid=1 -> all outputs at reset values asynchronously; after release a write of 0x3C is the first output byte.
